// File: rtl/fw_ram_pkg.sv
// Shared definitions for the firmware RAM bus front end: FSM encoding,
// RAM geometry and the data returned on denied or failed accesses.
package fw_ram_pkg;

  localparam int unsigned FW_RAM_WORDS  = 512;
  localparam int unsigned FW_RAM_AWIDTH = 9;

  // Read data returned on denied and timed-out accesses.
  localparam logic [31:0] DENY_RDATA = 32'h0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccess = 3'd1,
    StWait   = 3'd2,
    StTerr   = 3'd3,
    StResp   = 3'd4,
    StDeny   = 3'd5
  } fw_state_e;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fw_ram_violation_log.sv
// Sticky access-violation flag plus saturating 8-bit denial counter.
// A denial arriving in the same cycle as a clear wins and restarts the count at 1.
module fw_ram_violation_log
  import fw_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       deny,
  input  logic       clear,
  output logic       violation,
  output logic [7:0] violation_count
);

  logic       flag_d, flag_q;
  logic [7:0] count_d, count_q;

  // Next-state: deny has priority over clear.
  always_comb begin
    flag_d  = flag_q;
    count_d = count_q;
    if (deny) begin
      flag_d  = 1'b1;
      count_d = clear ? 8'd1 : sat_inc8(count_q);
    end else if (clear) begin
      flag_d  = 1'b0;
      count_d = 8'd0;
    end
  end

  // Flag and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      flag_q  <= flag_d;
      count_q <= count_d;
    end
  end

  assign violation       = flag_q;
  assign violation_count = count_q;

endmodule

// File: rtl/fw_ram_access_ctrl.sv
// CPU-bus front end of the 512 x 32 firmware RAM. Decodes the RAM window,
// turns each allowed access into a one-cycle RAM strobe, waits (bounded) for
// the RAM's registered ready, and answers app-mode accesses locally.
module fw_ram_access_ctrl
  import fw_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     system_mode,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [3:0]               mem_wstrb,
  input  logic [31:0]              mem_wdata,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic                     ram_cs,
  output logic [3:0]               ram_we,
  output logic [FW_RAM_AWIDTH-1:0] ram_address,
  output logic [31:0]              ram_write_data,
  input  logic [31:0]              ram_read_data,
  input  logic                     ram_ready,
  input  logic                     violation_clear,
  output logic                     violation,
  output logic [7:0]               violation_count,
  output logic                     timeout_error
);

  // Last WAIT count before giving up on ram_ready.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  fw_state_e state_d, state_q;

  logic [FW_RAM_AWIDTH-1:0] addr_d, addr_q;
  logic [3:0]               wstrb_d, wstrb_q;
  logic [31:0]              wdata_d, wdata_q;
  logic [31:0]              rdata_d, rdata_q;
  logic [7:0]               tcnt_d, tcnt_q;
  logic                     terr_d, terr_q;

  logic hit;
  logic accept;

  // Byte offset within the word is irrelevant to a word-wide RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  assign hit    = (mem_addr[31:11] == BASE_ADDR[31:11]);
  assign accept = (state_q == StIdle) && mem_valid && hit && !system_mode;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; system_mode only matters at acceptance in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (mem_valid && hit) begin
          state_d = system_mode ? StDeny : StAccess;
        end
      end
      StAccess: state_d = StWait;
      StWait: begin
        if (ram_ready) begin
          state_d = StResp;
        end else if (tcnt_q == TimeoutLast) begin
          state_d = StTerr;
        end
      end
      StTerr, StResp, StDeny: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: request latch, timeout counter, read capture, timeout flag.
  always_comb begin
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tcnt_d  = tcnt_q;
    terr_d  = terr_q;

    if (accept) begin
      addr_d  = mem_addr[FW_RAM_AWIDTH+1:2];
      wstrb_d = mem_wstrb;
      wdata_d = mem_wdata;
    end

    if (state_q == StAccess) begin
      tcnt_d = 8'd0;
    end else if (state_q == StWait && !ram_ready) begin
      tcnt_d = tcnt_q + 8'd1;
    end

    // Captured on writes too; the response path masks it out.
    if (state_q == StWait && ram_ready) begin
      rdata_d = ram_read_data;
    end

    if (state_q == StTerr) begin
      terr_d = 1'b1;
    end else if (violation_clear) begin
      terr_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      tcnt_q  <= 8'd0;
      terr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_d;
    end
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    ram_cs         = 1'b0;
    ram_we         = 4'h0;
    ram_address    = addr_q;
    ram_write_data = wdata_q;
    mem_ready      = 1'b0;
    mem_rdata      = DENY_RDATA;
    case (state_q)
      StAccess: begin
        ram_cs = 1'b1;
        ram_we = wstrb_q;
      end
      StResp: begin
        mem_ready = 1'b1;
        mem_rdata = (wstrb_q == 4'h0) ? rdata_q : 32'h0;
      end
      StDeny, StTerr: begin
        mem_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign timeout_error = terr_q;

  fw_ram_violation_log u_violation_log (
    .clk             (clk),
    .reset           (reset),
    .deny            (state_q == StDeny),
    .clear           (violation_clear),
    .violation       (violation),
    .violation_count (violation_count)
  );

endmodule

// File: tb/tb_fw_ram_access_ctrl.sv
// Directed bench for fw_ram_access_ctrl with a registered RAM model and a
// queue of expected read data per issued request.
module tb_fw_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        system_mode = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_cs;
  logic [3:0]  ram_we;
  logic [8:0]  ram_address;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data = 32'h0;
  logic        ram_ready;
  logic        violation_clear = 1'b0;
  logic        violation;
  logic [7:0]  violation_count;
  logic        timeout_error;

  logic        model_ready = 1'b0;
  logic        ram_dead = 1'b0;
  logic        force_ready = 1'b0;
  logic        flip_mode = 1'b0;
  logic        drop_valid = 1'b0;
  logic [31:0] ram_mem [512];
  logic [31:0] sb_q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fw_ram_access_ctrl #(
    .BASE_ADDR      (32'h0001_0000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .system_mode     (system_mode),
    .mem_valid       (mem_valid),
    .mem_addr        (mem_addr),
    .mem_wstrb       (mem_wstrb),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .ram_cs          (ram_cs),
    .ram_we          (ram_we),
    .ram_address     (ram_address),
    .ram_write_data  (ram_write_data),
    .ram_read_data   (ram_read_data),
    .ram_ready       (ram_ready),
    .violation_clear (violation_clear),
    .violation       (violation),
    .violation_count (violation_count),
    .timeout_error   (timeout_error)
  );

  // Registered RAM: ready one cycle after cs unless the model is told to stay silent.
  always @(posedge clk) begin
    model_ready   <= ram_cs && !ram_dead;
    ram_read_data <= ram_mem[ram_address];
    if (ram_cs) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) ram_mem[ram_address][b*8 +: 8] <= ram_write_data[b*8 +: 8];
      end
    end
  end
  assign ram_ready = model_ready | force_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for mem_ready, and check latency, RAM strobe and data.
  task automatic access(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic mode, input logic [31:0] exp_rdata,
                        input int exp_lat, input int exp_cs);
    int          lat = 0;
    int          cs_seen = 0;
    int          stray = 0;
    logic        got = 1'b0;
    logic [8:0]  cs_addr = 9'h0;
    logic [3:0]  cs_we = 4'h0;
    logic [31:0] cs_wd = 32'h0;
    logic [31:0] rd = 32'hxxxx_xxxx;
    logic [31:0] exp;
    logic [8:0]  exp_word;
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_addr    = addr;
    mem_wstrb   = strb;
    mem_wdata   = wdata;
    system_mode = mode;
    sb_q.push_back(exp_rdata);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ram_cs) begin
        cs_seen++;
        cs_addr = ram_address;
        cs_we   = ram_we;
        cs_wd   = ram_write_data;
      end
      if (mem_ready) begin
        got = 1'b1;
        rd  = mem_rdata;
      end else if (mem_rdata !== 32'h0) begin
        stray++;
      end
      if (lat == 1) begin
        if (flip_mode) system_mode = ~mode;
        if (drop_valid) mem_valid = 1'b0;
      end
    end
    mem_valid   = 1'b0;
    mem_wstrb   = 4'h0;
    system_mode = 1'b0;
    exp = sb_q.pop_front();
    check({tag, ".ready"}, 32'(got), 32'd1);
    check({tag, ".rdata"}, rd, exp);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".cs_pulses"}, cs_seen, exp_cs);
    check({tag, ".rdata_idle_nonzero"}, stray, 0);
    if (exp_cs != 0) begin
      exp_word = addr[10:2];
      check({tag, ".ram_address"}, 32'(cs_addr), 32'(exp_word));
      check({tag, ".ram_we"}, 32'(cs_we), 32'(strb));
      if (strb != 4'h0) check({tag, ".ram_wdata"}, cs_wd, wdata);
    end
  endtask

  initial begin
    int ready_seen;
    int cs_seen;

    // Reset state.
    @(negedge clk);
    check("rst.mem_ready", 32'(mem_ready), 0);
    check("rst.mem_rdata", mem_rdata, 0);
    check("rst.ram_cs", 32'(ram_cs), 0);
    check("rst.ram_we", 32'(ram_we), 0);
    check("rst.ram_address", 32'(ram_address), 0);
    check("rst.violation", 32'(violation), 0);
    check("rst.count", 32'(violation_count), 0);
    check("rst.timeout", 32'(timeout_error), 0);
    reset = 1'b0;

    // Firmware-mode write then read back.
    access("wr", 32'h0001_0010, 4'hF, 32'hCAFE_BABE, 1'b0, 32'h0, 3, 1);
    access("rd", 32'h0001_0010, 4'h0, 32'h0, 1'b0, 32'hCAFE_BABE, 3, 1);

    // Byte lanes, ignored low address bits, top word of the window.
    access("wr5full", 32'h0001_0014, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 3, 1);
    access("wr5lo", 32'h0001_0014, 4'h3, 32'h1234_5678, 1'b0, 32'h0, 3, 1);
    access("rd5", 32'h0001_0017, 4'h0, 32'h0, 1'b0, 32'hFFFF_5678, 3, 1);
    access("wrtop", 32'h0001_07FC, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, 3, 1);
    access("rdtop", 32'h0001_07FC, 4'h0, 32'h0, 1'b0, 32'h0BAD_F00D, 3, 1);

    // Mode flip and valid drop after acceptance do not disturb the access.
    flip_mode  = 1'b1;
    drop_valid = 1'b1;
    access("midchg", 32'h0001_0010, 4'h0, 32'h0, 1'b0, 32'hCAFE_BABE, 3, 1);
    flip_mode  = 1'b0;
    drop_valid = 1'b0;
    check("midchg.violation", 32'(violation), 0);

    // App-mode denial.
    access("deny", 32'h0001_0000, 4'h0, 32'h0, 1'b1, 32'h0, 1, 0);
    @(negedge clk);
    check("deny.violation", 32'(violation), 1);
    check("deny.count", 32'(violation_count), 1);
    for (int i = 0; i < 299; i++) begin
      access("deny_loop", 32'h0001_0000, 4'hF, 32'h1111_1111, 1'b1, 32'h0, 1, 0);
    end
    @(negedge clk);
    check("sat.count", 32'(violation_count), 255);

    // Clear without a denial.
    violation_clear = 1'b1;
    @(negedge clk);
    violation_clear = 1'b0;
    check("clr.violation", 32'(violation), 0);
    check("clr.count", 32'(violation_count), 0);

    // Silent RAM: 8 WAIT cycles then an error response.
    ram_dead = 1'b1;
    access("tmo", 32'h0001_0000, 4'h0, 32'h0, 1'b0, 32'h0, 10, 1);
    ram_dead = 1'b0;
    @(negedge clk);
    check("tmo.flag", 32'(timeout_error), 1);
    violation_clear = 1'b1;
    @(negedge clk);
    violation_clear = 1'b0;
    check("tmo.clear", 32'(timeout_error), 0);

    // Late ram_ready while idle is ignored.
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    check("late.ready", 32'(mem_ready), 0);
    @(negedge clk);
    check("late.ready2", 32'(mem_ready), 0);
    check("late.cs", 32'(ram_cs), 0);

    // Non-hit request is ignored for 20 cycles.
    ready_seen = 0;
    cs_seen    = 0;
    mem_valid  = 1'b1;
    mem_addr   = 32'h0002_0000;
    mem_wstrb  = 4'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready) ready_seen++;
      if (ram_cs) cs_seen++;
    end
    mem_valid = 1'b0;
    check("miss.ready", ready_seen, 0);
    check("miss.cs", cs_seen, 0);

    // Clear coincident with a denial: the denial wins and the count restarts at 1.
    access("deny_a", 32'h0001_0000, 4'h0, 32'h0, 1'b1, 32'h0, 1, 0);
    access("deny_b", 32'h0001_0000, 4'h0, 32'h0, 1'b1, 32'h0, 1, 0);
    @(negedge clk);
    check("pre.count", 32'(violation_count), 2);
    mem_valid   = 1'b1;
    mem_addr    = 32'h0001_0000;
    system_mode = 1'b1;
    @(negedge clk);
    check("coinc.ready", 32'(mem_ready), 1);
    mem_valid       = 1'b0;
    system_mode     = 1'b0;
    violation_clear = 1'b1;
    @(negedge clk);
    violation_clear = 1'b0;
    check("coinc.violation", 32'(violation), 1);
    check("coinc.count", 32'(violation_count), 1);

    // Asynchronous reset while waiting on the RAM.
    access("wr64", 32'h0001_0100, 4'hF, 32'hA5A5_5A5A, 1'b0, 32'h0, 3, 1);
    ram_dead  = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0001_0100;
    mem_wstrb = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("wait.cs", 32'(ram_cs), 0);
    check("wait.address", 32'(ram_address), 32'd64);
    #2 reset = 1'b1;
    #1;
    check("arst.mem_ready", 32'(mem_ready), 0);
    check("arst.ram_address", 32'(ram_address), 0);
    check("arst.ram_wdata", ram_write_data, 0);
    check("arst.violation", 32'(violation), 0);
    check("arst.count", 32'(violation_count), 0);
    check("arst.timeout", 32'(timeout_error), 0);
    @(negedge clk);
    reset     = 1'b0;
    mem_valid = 1'b0;
    ram_dead  = 1'b0;
    access("post_rst", 32'h0001_0100, 4'h0, 32'h0, 1'b0, 32'hA5A5_5A5A, 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fw_ram_access_ctrl.md
Name: fw_ram_access_ctrl

Overview:
- Bus-side front end of the 512 x 32 firmware RAM; sits between the CPU memory bus (valid/ready, byte strobes) and the RAM's cs/we/address/ready port.
- Decodes the RAM window and converts each CPU access into a single-cycle RAM strobe, then waits for the RAM's registered ready.
- Enforces mode-based access control: accesses in app mode are denied, answered locally, and logged.
- Provides a timeout so a missing RAM ready can never hang the CPU.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte base of the 2 KiB RAM window (bits [10:0] must be 0).
- TIMEOUT_CYCLES, 8, max cycles waiting for ram_ready before an error response (2..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- system_mode  in  1  0 = firmware mode (access allowed), 1 = app mode (access denied).
- mem_valid  in  1  CPU request; held until mem_ready.
- mem_addr  in  32  CPU byte address.
- mem_wstrb  in  4  byte write strobes; 0 = read.
- mem_wdata  in  32  CPU write data.
- mem_ready  out  1  one-cycle response strobe.
- mem_rdata  out  32  read data; valid only while mem_ready=1, else 0.
- ram_cs  out  1  RAM chip select.
- ram_we  out  4  RAM write enables.
- ram_address  out  9  RAM word address.
- ram_write_data  out  32  RAM write data.
- ram_read_data  in  32  RAM read data.
- ram_ready  in  1  RAM ready, registered in the RAM; high one cycle after cs.
- violation_clear  in  1  clears the violation flag and count.
- violation  out  1  sticky flag: an access was denied.
- violation_count  out  8  number of denied accesses, saturating at 255.
- timeout_error  out  1  sticky flag: a RAM access timed out; cleared by violation_clear.

Behaviour:
- Reset (async, any state): FSM -> IDLE; all outputs 0; latched address, strobes, data and rdata = 0; counters = 0.
- Hit decode: mem_addr[31:11] == BASE_ADDR[31:11]. Word address = mem_addr[10:2]. mem_addr[1:0] is ignored.
- Non-hit requests are ignored entirely: no mem_ready and no state change.
- IDLE:
  - mem_valid && hit && !system_mode -> ACCESS; latch word address, mem_wstrb and mem_wdata.
  - mem_valid && hit && system_mode -> DENY.
- ACCESS (1 cycle): ram_cs=1, ram_we=latched strobes, ram_address/ram_write_data from the latch. Next state WAIT; timeout counter loads 0.
- WAIT: ram_cs=0, ram_we=0.
  - ram_ready=1 -> capture ram_read_data (captured for writes too) -> RESP.
  - Otherwise the counter increments; when counter == TIMEOUT_CYCLES-1 with no ready -> TERR.
- RESP (1 cycle): mem_ready=1; mem_rdata=captured data for reads, 0 for writes -> IDLE.
- DENY (1 cycle): mem_ready=1, mem_rdata=0; no RAM strobe; violation<=1; violation_count increments saturating -> IDLE.
- TERR (1 cycle): mem_ready=1, mem_rdata=0; timeout_error<=1 -> IDLE.
- Nominal latency, mem_valid accepted to mem_ready: 3 cycles (IDLE accept, ACCESS, WAIT sees ready, RESP). The deny path takes 1 cycle.
- system_mode is sampled only at acceptance in IDLE; a change mid-access does not abort the access.
- mem_valid dropping mid-access is ignored; the access completes.
- Back-to-back: after RESP, DENY or TERR the FSM is in IDLE and may accept a new request on the next cycle.
- violation_clear together with a new DENY in the same cycle: DENY wins; violation=1, count=1.
- violation_clear with no DENY: violation=0, count=0, timeout_error=0.
- A late ram_ready arriving in IDLE is ignored.
- ram_address and ram_write_data hold their last latched value outside ACCESS; ram_we is 0 outside ACCESS.

Decomposition:
- Shared package fw_ram_pkg:
  - FSM state encoding (IDLE, ACCESS, WAIT, TERR, RESP, DENY), 3 bits.
  - FW_RAM_WORDS = 512, FW_RAM_AWIDTH = 9.
  - DENY_RDATA = 32'h0.
- Optional sub-module fw_ram_violation_log: sticky flag plus saturating 8-bit counter with clear/priority logic. Everything else stays flat.

Test Plan:
- Firmware-mode write mem_addr=0x0001_0010, wstrb=4'hF, wdata=0xCAFEBABE -> ram_cs pulses 1 cycle with ram_address=4, ram_we=F; mem_ready 3 cycles after accept; mem_rdata=0.
- Read back the same address with a RAM model returning 0xCAFEBABE -> mem_rdata=0xCAFEBABE while mem_ready=1; 0 otherwise.
- App mode (system_mode=1) read of 0x0001_0000 -> mem_ready next cycle, mem_rdata=0, no ram_cs, violation=1, count=1; 300 denials -> count=255.
- RAM model never asserts ram_ready, TIMEOUT_CYCLES=8 -> mem_ready after 8 WAIT cycles, mem_rdata=0, timeout_error=1; violation_clear -> 0.
- Request at 0x0002_0000 (non-hit) -> no mem_ready and no ram_cs for 20 cycles.
- Assert reset in WAIT -> all outputs 0 immediately (async); next hit request after release completes normally; violation_clear coincident with DENY -> count=1.
